muldiv_seq: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MCCPU execute stage.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer: ALU opcodes,
// MDU op codes, FSM state encodings and the magnitude helper.
package muldiv_seq_pkg;

    localparam int MDU_W = 32;

    // Opcodes of the shared execute-stage ALU that this block drives
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;

    // Two's complement magnitude when treated as signed; 0x8000_0000 maps to itself.
    function automatic logic [MDU_W-1:0] mag_of(input logic [MDU_W-1:0] v, input logic is_signed);
        return (is_signed && v[MDU_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result handshake plus the borrowed-ALU operand path of the sequencer.
interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    logic              start;
    mdu_op_t           op;
    logic [MDU_W-1:0]  a;
    logic [MDU_W-1:0]  b;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [MDU_W-1:0]  hi;
    logic [MDU_W-1:0]  lo;
    logic [MDU_W-1:0]  alu_a;
    logic [MDU_W-1:0]  alu_b;
    logic [3:0]        alu_op;
    logic [MDU_W-1:0]  alu_c;

    modport slave (
        input  start, op, a, b, alu_c,
        output busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_op
    );

    modport master (
        output start, op, a, b, alu_c,
        input  busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer: shift-add multiply and restoring divide on
// operand magnitudes using one external ALU add/subtract per cycle, then sign fix-up.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MDU_W
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t        state_q, state_d;
    mdu_op_t           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0]  low_q, low_d;     // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]  opb_q, opb_d;     // multiplicand / divisor
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dbz_q, dbz_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic [WIDTH-1:0]    alu_a_c, alu_b_c;
    logic [3:0]          alu_op_c;
    logic                carry_c, ge_c;
    logic [WIDTH-1:0]    sum_c, shifted_c;
    logic [2*WIDTH-1:0]  prod_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULTU;
            cnt_q   <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opb_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opb_q   <= opb_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opb_d     = opb_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        alu_a_c   = '0;
        alu_b_c   = '0;
        alu_op_c  = ALU_NOP;
        carry_c   = 1'b0;
        ge_c      = 1'b0;
        sum_c     = '0;
        shifted_c = '0;
        prod_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    // Raw operands are captured here so the caller need not hold a/b through PREP
                    low_d = bus.a;
                    opb_d = bus.b;
                    if (bus.op[1] && (bus.b == '0)) begin
                        hi_d    = bus.a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_PREP;
                    end
                end
            end

            ST_PREP: begin
                low_d   = mag_of(low_q, op_q[0]);
                opb_d   = mag_of(opb_q, op_q[0]);
                negq_d  = op_q[0] & (low_q[WIDTH-1] ^ opb_q[WIDTH-1]);
                negr_d  = op_q[0] & low_q[WIDTH-1];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_ITER;
            end

            ST_ITER: begin
                if (!op_q[1]) begin
                    alu_op_c = ALU_ADD;
                    alu_a_c  = acc_q;
                    alu_b_c  = opb_q;
                    if (low_q[0]) begin
                        carry_c = (bus.alu_c < acc_q);
                        sum_c   = bus.alu_c;
                    end else begin
                        sum_c   = acc_q;
                    end
                    acc_d = {carry_c, sum_c[WIDTH-1:1]};
                    low_d = {sum_c[0], low_q[WIDTH-1:1]};
                end else begin
                    shifted_c = {acc_q[WIDTH-2:0], low_q[WIDTH-1]};
                    alu_op_c  = ALU_SUB;
                    alu_a_c   = shifted_c;
                    alu_b_c   = opb_q;
                    // A set remainder MSB means the shifted value has bit WIDTH, so it always fits
                    ge_c      = acc_q[WIDTH-1] | !(shifted_c < opb_q);
                    acc_d     = ge_c ? bus.alu_c : shifted_c;
                    low_d     = {low_q[WIDTH-2:0], ge_c};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (!op_q[1]) begin
                    prod_c = {acc_q, low_q};
                    if (negq_q) begin
                        prod_c = ~prod_c + 1'b1;
                    end
                    hi_d = prod_c[2*WIDTH-1:WIDTH];
                    lo_d = prod_c[WIDTH-1:0];
                end else begin
                    lo_d = negq_q ? (~low_q + 1'b1) : low_q;
                    hi_d = negr_q ? (~acc_q + 1'b1) : acc_q;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;
    assign bus.alu_op      = alu_op_c;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a vector table of MDU operations with hand-computed
// results and latencies, plus start-while-busy and mid-operation reset sequences.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model of the shared execute-stage ALU
    assign bus.alu_c = (bus.alu_op == ALU_ADD) ? (bus.alu_a + bus.alu_b) :
                       (bus.alu_op == ALU_SUB) ? (bus.alu_a - bus.alu_b) : 32'h0;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns at #1 after the edge that accepts start, i.e. in cycle N+1
    task automatic issue(input mdu_op_t o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lat_in, output int lat);
        lat = lat_in;
        while (!bus.done && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35};
        vecs[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35};
        vecs[2]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35};
        vecs[3]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
        vecs[4]  = '{MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 35};
        vecs[5]  = '{MDU_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35};
        vecs[7]  = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35};
        vecs[8]  = '{MDU_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 35};
        vecs[9]  = '{MDU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[10] = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 35};
        vecs[11] = '{MDU_DIVU,  32'h0000_0003, 32'h0000_0010, 32'h0000_0003, 32'h0000_0000, 1'b0, 35};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = MDU_MULTU;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   64'(bus.busy), 64'd0);
        chk("reset_done",   64'(bus.done), 64'd0);
        chk("reset_dbz",    64'(bus.div_by_zero), 64'd0);
        chk("reset_hilo",   {bus.hi, bus.lo}, 64'd0);
        chk("reset_aluop",  64'(bus.alu_op), 64'(ALU_NOP));
        chk("reset_aluab",  {bus.alu_a, bus.alu_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk("busy_after_start", 64'(bus.busy), 64'd1);
            wait_done(1, lat);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, bus.div_by_zero, lat);
            chk("latency", 64'(lat), 64'(vecs[i].lat));
            chk("hi",      64'(bus.hi), 64'(vecs[i].hi));
            chk("lo",      64'(bus.lo), 64'(vecs[i].lo));
            chk("dbz",     64'(bus.div_by_zero), 64'(vecs[i].dbz));
            chk("busy_at_done", 64'(bus.busy), 64'd1);
            @(posedge clk);
            #1;
            chk("idle_after_done", {62'd0, bus.busy, bus.done}, 64'd0);
            chk("hilo_held", {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
        end

        // Second start mid-ITER must be ignored; previous results held until FIX
        issue(MDU_MULTU, 32'd6, 32'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("mid_aluop_add", 64'(bus.alu_op), 64'(ALU_ADD));
        chk("mid_hilo_held", {bus.hi, bus.lo}, {32'h0000_0003, 32'h0000_0000});
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd1;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(12, lat);
        $display("ignored-start MULTU 6*7 -> hi=%h lo=%h dbz=%0b lat=%0d",
                 bus.hi, bus.lo, bus.div_by_zero, lat);
        chk("ign_latency", 64'(lat), 64'd35);
        chk("ign_hilo",    {bus.hi, bus.lo}, {32'h0, 32'h0000_002A});
        chk("ign_dbz",     64'(bus.div_by_zero), 64'd0);
        @(posedge clk);
        #1;

        // Reset while ITER is at count 10 (cycle N+12)
        issue(MDU_MULTU, 32'd6, 32'd7);
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_aluop", 64'(bus.alu_op), 64'(ALU_NOP));
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        $display("reset mid-ITER -> busy=%0b hi=%h lo=%h done_pulses=%0d",
                 bus.busy, bus.hi, bus.lo, done_seen);
        chk("rst_no_done", 64'(done_seen), 64'd0);

        // Normal operation resumes after the abort
        issue(MDU_MULT, 32'hFFFF_FFFA, 32'd7);
        wait_done(1, lat);
        $display("post-reset MULT -6*7 -> hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
        chk("post_latency", 64'(lat), 64'd35);
        chk("post_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFD6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
